// File: rtl/inst_fetch_unit.sv
// Multi-word instruction fetch unit: assembles INST_WORDS memory words into one
// bundle using a req/ack memory handshake, with decode backpressure, redirect
// and halt support.
module inst_fetch_unit #(
    parameter int unsigned            DATA_W     = 16,
    parameter int unsigned            ADDR_W     = 16,
    parameter int unsigned            INST_WORDS = 4,
    parameter logic [ADDR_W-1:0]      RESET_PC   = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         mem_req,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic                         mem_ack,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic                         inst_valid,
    input  logic                         inst_ready,
    output logic [INST_WORDS*DATA_W-1:0] inst_bundle,
    output logic [ADDR_W-1:0]            inst_pc,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirect_pc,
    input  logic                         halt,
    output logic                         busy
);

    localparam int unsigned IDX_W    = (INST_WORDS > 1) ? $clog2(INST_WORDS) : 1;
    localparam int unsigned BUNDLE_W = INST_WORDS * DATA_W;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t                  state_q;
    logic [ADDR_W-1:0]       fetch_ptr_q;
    logic [IDX_W-1:0]        word_idx_q;
    logic [BUNDLE_W-1:0]     bundle_q;
    logic [ADDR_W-1:0]       inst_pc_q;
    logic                    last_word;

    assign last_word = (word_idx_q == IDX_W'(INST_WORDS - 1));

    // Fetch sequencing: redirect overrides everything, then per-state progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_FETCH;
            fetch_ptr_q <= RESET_PC;
            word_idx_q  <= '0;
            bundle_q    <= '0;
            inst_pc_q   <= RESET_PC;
        end else if (redirect) begin
            // Any ack in this cycle belongs to the abandoned stream and is dropped.
            state_q     <= S_FETCH;
            fetch_ptr_q <= redirect_pc;
            word_idx_q  <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ack) begin
                        bundle_q[int'(word_idx_q)*DATA_W +: DATA_W] <= mem_rdata;
                        fetch_ptr_q <= fetch_ptr_q + ADDR_W'(1);
                        if (word_idx_q == '0) begin
                            inst_pc_q <= fetch_ptr_q;
                        end
                        if (last_word) begin
                            word_idx_q <= '0;
                            state_q    <= S_HOLD;
                        end else begin
                            word_idx_q <= word_idx_q + IDX_W'(1);
                        end
                    end
                end
                S_HOLD: begin
                    // Halt is only looked at when decode takes the bundle.
                    if (inst_ready) begin
                        state_q <= halt ? S_HALTED : S_FETCH;
                    end
                end
                S_HALTED: begin
                    state_q <= S_HALTED;
                end
                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

    // Outputs decoded from registered state; reset forces the request low.
    assign mem_req     = rst && (state_q == S_FETCH);
    assign busy        = mem_req;
    assign mem_addr    = fetch_ptr_q;
    assign inst_valid  = (state_q == S_HOLD);
    assign inst_bundle = bundle_q;
    assign inst_pc     = inst_pc_q;

endmodule
